alu_seq: RTL and testbench
==========================

# alu_seq

Command sequencer that drives the team's 4-bit combinational ALU from the initiator side. It accepts one operation command at a time over a valid/ready handshake. It reads two operands from a small internal register file and presents them with the opcode on registered ALU-facing outputs. It then captures the ALU result back into a destination register and pulses completion. It sits between test/control logic and the ALU, acting as the operand and opcode source the ALU itself lacks.

## Interface
- W, 4, data width of registers and ALU operands/result
- NREG, 4, register-file entries (power of two; address width = log2(NREG))
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  ALU opcode: 00 add, 01 sub, 10 and, 11 or
- cmd_rs / cmd_rt  in  log2(NREG) each  source register indices (A, B)
- cmd_rd  in  log2(NREG)  destination register index
- ld_en  in  1  direct register load strobe
- ld_addr  in  log2(NREG)  load address
- ld_data  in  W  load value
- alu_a / alu_b  out  W each  operands to ALU
- alu_op  out  2  opcode to ALU
- alu_c  in  W  ALU result (combinational from alu_a/alu_b/alu_op)
- done  out  1  one-cycle completion pulse
- rd_addr  in  log2(NREG)  debug read address
- rd_data  out  W  combinational read of register rd_addr
- zero  out  1  last result was zero (only with ALU_SEQ_ZERO_FLAG_EN)

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, the block registers these values and goes to ISSUE:
  - alu_a <= reg[cmd_rs], alu_b <= reg[cmd_rt]
  - alu_op <= cmd_op, latched rd <= cmd_rd
- ISSUE: cmd_ready=0. At the end of the cycle, reg[rd] <= alu_c. Then go to DONE.
- DONE: done=1, cmd_ready=0. Next state is IDLE.
- alu_a/alu_b/alu_op hold their values from acceptance until the next acceptance.
- Arithmetic is modulo 2^W, performed by the ALU. The sequencer neither widens nor checks the result.
- Loads: ld_en writes reg[ld_addr] <= ld_data in any state.
- If a load and an ISSUE writeback target the same register on the same edge, the writeback wins.
- Operand read at acceptance sees pre-edge contents. A load to rs/rt on the accept edge is not seen by that command.
- cmd_rs = cmd_rt and cmd_rd = cmd_rs are legal.
- cmd_valid outside IDLE is ignored and must not be lost silently by the source; hold it until ready.

## Timing
- Accept at edge T; writeback at edge T+1; done high in cycle T+1..T+2; cmd_ready high again from T+2. Throughput is one command per 3 cycles.
- Reset (any state, including mid-ISSUE):
  - state=IDLE, all registers 0, alu_a/alu_b/alu_op 0, done 0, zero 0.
  - A pending writeback is discarded.
  - Commands presented while reset is high are not accepted. cmd_ready follows state and reads 1 during and after reset.
- rd_data is combinational from the register file. It shows a write on the cycle after the write edge.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined: the zero port exists. On the ISSUE writeback edge, zero <= (alu_c == 0). zero holds until the next writeback, resets to 0, and is unaffected by loads.
- Undefined: the zero port and its flop are absent. All other behaviour is identical.

## Structure
- Package alu_seq_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - state encoding IDLE/ISSUE/DONE
- Sub-module alu_seq_regfile: NREG×W storage with two combinational read ports for operands, one debug read port, and a write port.
- The write port is prioritized with writeback over load.

## Test plan
- Load r0=5, r1=3; cmd ADD rs=0 rt=1 rd=2 → alu_a=5, alu_b=3, alu_op=00 one cycle after accept; r2=8; done is a single pulse 2 cycles after accept.
- Cmd SUB rs=1 rt=0 rd=3 with r0=5, r1=3 → r3=4'hE (wrap); cmd_ready low for exactly 2 cycles after accept.
- cmd_valid held high for two commands → second accepted exactly 3 cycles after first; alu outputs stable in between.
- ld_en to r2 with ld_data=7 on the ISSUE edge of a command with rd=2, result 1 → r2=1; load in IDLE to r2 → r2=7.
- Reset asserted during ISSUE → rd register stays 0, no done pulse, all outputs 0, cmd_ready=1.
- With ALU_SEQ_ZERO_FLAG_EN: r0=4'hA, r1=4'h5, AND → result 0, zero=1. A following OR → result 4'hF, zero=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - ALU opcode constants (OP_ADD/OP_SUB/OP_AND/OP_OR)
//   - sequencer state encoding (state_t)
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: command handshake between a command source and the sequencer.
//   valid/ready : handshake
//   op          : ALU opcode
//   rs/rt/rd    : source A, source B and destination register indices
// Modports: master = command source, slave = sequencer.
interface alu_seq_if #(
  parameter int AW = 2
);
  logic          valid;
  logic          ready;
  logic [1:0]    op;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;

  modport master (output valid, op, rs, rt, rd, input ready);
  modport slave  (input valid, op, rs, rt, rd, output ready);
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x W register file for the ALU sequencer.
//   clk, reset              : clock, synchronous active-high clear
//   ld_en/ld_addr/ld_data   : direct load port
//   wb_en/wb_addr/wb_data   : ALU result writeback (wins over a load to the same entry)
//   ra_addr/ra_data         : operand A read (combinational)
//   rb_addr/rb_data         : operand B read (combinational)
//   rd_addr/rd_data         : debug read (combinational)
module alu_seq_regfile #(
  parameter int W    = 4,
  parameter int NREG = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else begin
      if (ld_en) mem[ld_addr] <= ld_data;
      // Later assignment wins: writeback overrides a same-address load.
      if (wb_en) mem[wb_addr] <= wb_data;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving a combinational 4-bit ALU.
// Accepts one command over cmd (valid/ready), presents registered operands
// and opcode to the ALU, writes the ALU result back into the destination
// register one cycle later and pulses done.
//   clk, reset             : clock, synchronous active-high reset
//   cmd                    : command interface (slave modport)
//   ld_en/ld_addr/ld_data  : direct register load, allowed in any state
//   alu_a/alu_b/alu_op     : registered ALU inputs
//   alu_c                  : ALU result
//   done                   : one-cycle completion pulse
//   rd_addr/rd_data        : combinational debug read
//   zero                   : last writeback was zero (only when
//                            ALU_SEQ_ZERO_FLAG_EN is defined)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W    = 4,
  parameter int NREG = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_if.slave      cmd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_op,
  input  logic [W-1:0]  alu_c,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic          zero
`endif
);

  state_t        state;
  logic [AW-1:0] rd_q;
  logic [W-1:0]  ra_data;
  logic [W-1:0]  rb_data;
  logic          wb_en;

  assign cmd.ready = (state == ST_IDLE);
  assign wb_en     = (state == ST_ISSUE);

  alu_seq_regfile #(.W(W), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (wb_en),
    .wb_addr (rd_q),
    .wb_data (alu_c),
    .ra_addr (cmd.rs),
    .ra_data (ra_data),
    .rb_addr (cmd.rt),
    .rb_data (rb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_q   <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (cmd.valid) begin
            // Operands come from pre-edge contents; a load on this edge is not seen.
            alu_a  <= ra_data;
            alu_b  <= rb_data;
            alu_op <= cmd.op;
            rd_q   <= cmd.rd;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)         zero <= 1'b0;
    else if (wb_en)    zero <= (alu_c == '0);
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] alu_a, alu_b, alu_c;
  logic [1:0] alu_op;
  logic       done;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero;
`endif

  alu_seq_if #(.AW(2)) cmd_if ();

  alu_seq #(.W(4), .NREG(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .cmd     (cmd_if.slave),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_c   (alu_c),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .zero    (zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  // Environment ALU: combinational from the DUT's registered outputs.
  assign alu_c = alu_fn(alu_op, alu_a, alu_b);

  typedef struct {
    logic [1:0] rd;
    logic [3:0] val;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] mdl [4];
  int         ncmp = 0;
  int         nfail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    ncmp++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reg(string tag, int idx, logic [3:0] expv);
    rd_addr = 2'(idx);
    #1;
    chk(tag, 32'(rd_data), 32'(expv));
  endtask

  task automatic do_load(int idx, logic [3:0] val);
    ld_en   = 1'b1;
    ld_addr = 2'(idx);
    ld_data = val;
    step();
    ld_en   = 1'b0;
    mdl[idx] = val;
  endtask

  // Present a command in IDLE; returns after the accept edge with checks on the ALU outputs.
  task automatic issue(string tag, logic [1:0] op, int rs, int rt, int rd);
    exp_t e;
    logic [3:0] a, b;
    a = mdl[rs];
    b = mdl[rt];
    e.rd  = 2'(rd);
    e.val = alu_fn(op, a, b);
    sbq.push_back(e);
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.rs    = 2'(rs);
    cmd_if.rt    = 2'(rt);
    cmd_if.rd    = 2'(rd);
    step();
    cmd_if.valid = 1'b0;
    ld_en        = 1'b0;
    chk({tag, "_alu_a"},  32'(alu_a),  32'(a));
    chk({tag, "_alu_b"},  32'(alu_b),  32'(b));
    chk({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, "_ready_t1"}, 32'(cmd_if.ready), 32'd0);
    chk({tag, "_done_t1"},  32'(done), 32'd0);
  endtask

  // Writeback edge and done pulse; pops the scoreboard and checks the destination.
  task automatic finish_cmd(string tag);
    exp_t e;
    step();
    ld_en = 1'b0;
    chk({tag, "_done_t2"},  32'(done), 32'd1);
    chk({tag, "_ready_t2"}, 32'(cmd_if.ready), 32'd0);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk_reg({tag, "_wb"}, int'(e.rd), e.val);
      mdl[e.rd] = e.val;
    end
    step();
    chk({tag, "_done_t3"},  32'(done), 32'd0);
    chk({tag, "_ready_t3"}, 32'(cmd_if.ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    reset        = 1'b1;
    cmd_if.valid = 1'b0;
    cmd_if.op    = '0;
    cmd_if.rs    = '0;
    cmd_if.rt    = '0;
    cmd_if.rd    = '0;
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    rd_addr      = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", 32'(cmd_if.ready), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst_zero", 32'(zero), 32'd0);
`endif
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", i, 4'h0);

    // ADD r2 = r0 + r1
    do_load(0, 4'h5);
    do_load(1, 4'h3);
    chk_reg("ld_r0", 0, 4'h5);
    issue("add", OP_ADD, 0, 1, 2);
    finish_cmd("add");

    // SUB with wrap: r3 = 3 - 5 = E
    issue("sub", OP_SUB, 1, 0, 3);
    finish_cmd("sub");
    chk_reg("sub_const", 3, 4'hE);

    // Load to an operand register on the accept edge is not seen by that command.
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'h9;
    issue("ldacc", OP_ADD, 0, 1, 3);
    mdl[0] = 4'h9;
    finish_cmd("ldacc");
    chk_reg("ldacc_r0", 0, 4'h9);

    // Back-to-back with cmd_valid held high.
    e.rd = 2'd3; e.val = alu_fn(OP_AND, mdl[0], mdl[1]);
    sbq.push_back(e);
    cmd_if.valid = 1'b1; cmd_if.op = OP_AND;
    cmd_if.rs = 2'd0; cmd_if.rt = 2'd1; cmd_if.rd = 2'd3;
    step();
    cmd_if.op = OP_OR; cmd_if.rd = 2'd2;
    chk("b2b_op1", 32'(alu_op), 32'(OP_AND));
    chk("b2b_ready1", 32'(cmd_if.ready), 32'd0);
    step();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_hold_op", 32'(alu_op), 32'(OP_AND));
    e = sbq.pop_front();
    chk_reg("b2b_wb1", int'(e.rd), e.val);
    mdl[e.rd] = e.val;
    step();
    chk("b2b_ready2", 32'(cmd_if.ready), 32'd1);
    chk("b2b_hold_a", 32'(alu_a), 32'(mdl[0]));
    chk("b2b_hold_op2", 32'(alu_op), 32'(OP_AND));
    e.rd = 2'd2; e.val = alu_fn(OP_OR, mdl[0], mdl[1]);
    sbq.push_back(e);
    step();
    cmd_if.valid = 1'b0;
    chk("b2b_op2", 32'(alu_op), 32'(OP_OR));
    chk("b2b_ready3", 32'(cmd_if.ready), 32'd0);
    finish_cmd("b2b2");

    // Load and writeback to the same register on the ISSUE edge: writeback wins.
    issue("coll", OP_AND, 0, 1, 2);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'h7;
    finish_cmd("coll");
    chk_reg("coll_r2", 2, 4'h1);
    do_load(2, 4'h7);
    chk_reg("idle_ld_r2", 2, 4'h7);

    // Reset during ISSUE discards the writeback and the done pulse.
    issue("rstmid", OP_ADD, 0, 1, 1);
    reset = 1'b1;
    cmd_if.valid = 1'b1;
    step();
    sbq.delete();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    chk("rstmid_done",  32'(done), 32'd0);
    chk("rstmid_ready", 32'(cmd_if.ready), 32'd1);
    chk("rstmid_alu_a", 32'(alu_a), 32'd0);
    chk("rstmid_alu_b", 32'(alu_b), 32'd0);
    chk("rstmid_alu_op", 32'(alu_op), 32'd0);
    step();
    reset = 1'b0;
    cmd_if.valid = 1'b0;
    chk("rstmid_noacc", 32'(cmd_if.ready), 32'd1);
    chk("rstmid_done2", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) chk_reg("rstmid_reg", i, 4'h0);

    // Zero-result path.
    do_load(0, 4'hA);
    do_load(1, 4'h5);
    issue("and0", OP_AND, 0, 1, 2);
    finish_cmd("and0");
    chk_reg("and0_r2", 2, 4'h0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("and0_zero", 32'(zero), 32'd1);
    do_load(3, 4'h0);
    chk("zero_ld_hold", 32'(zero), 32'd1);
`endif
    issue("orf", OP_OR, 0, 1, 3);
    finish_cmd("orf");
    chk_reg("orf_r3", 3, 4'hF);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("orf_zero", 32'(zero), 32'd0);
`endif

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
